// File: rtl/wbu_result_arbiter.sv
// Write-back arbiter: grants one of ALU/MUL/LSU per cycle onto the single register-file write port.
// Define WBU_RR_ARB_EN for round-robin arbitration; otherwise fixed priority LSU > MUL > ALU.
module wbu_result_arbiter #(
  parameter int NSRC            = 3,
  parameter int REG_DATA_WIDTH  = 32,
  parameter int REG_ADDR_WIDTH  = 5,
  parameter int COMMIT_ID_WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       alu_reg_we_i,
  input  logic [REG_ADDR_WIDTH-1:0]  alu_reg_waddr_i,
  input  logic [REG_DATA_WIDTH-1:0]  alu_result_i,
  input  logic [COMMIT_ID_WIDTH-1:0] alu_commit_id_i,
  output logic                       alu_wb_ready_o,
  input  logic                       mul_reg_we_i,
  input  logic [REG_ADDR_WIDTH-1:0]  mul_reg_waddr_i,
  input  logic [REG_DATA_WIDTH-1:0]  mul_result_i,
  input  logic [COMMIT_ID_WIDTH-1:0] mul_commit_id_i,
  output logic                       mul_wb_ready_o,
  input  logic                       lsu_reg_we_i,
  input  logic [REG_ADDR_WIDTH-1:0]  lsu_reg_waddr_i,
  input  logic [REG_DATA_WIDTH-1:0]  lsu_result_i,
  input  logic [COMMIT_ID_WIDTH-1:0] lsu_commit_id_i,
  output logic                       lsu_wb_ready_o,
  output logic                       reg_we_o,
  output logic [REG_ADDR_WIDTH-1:0]  reg_waddr_o,
  output logic [REG_DATA_WIDTH-1:0]  reg_wdata_o,
  output logic                       commit_valid_o,
  output logic [COMMIT_ID_WIDTH-1:0] commit_id_o
);

  logic [NSRC-1:0]            req;
  logic [NSRC-1:0]            gnt;
  logic [REG_ADDR_WIDTH-1:0]  src_waddr [NSRC];
  logic [REG_DATA_WIDTH-1:0]  src_data  [NSRC];
  logic [COMMIT_ID_WIDTH-1:0] src_id    [NSRC];

  assign req = {lsu_reg_we_i, mul_reg_we_i, alu_reg_we_i};
  assign src_waddr[0] = alu_reg_waddr_i;
  assign src_waddr[1] = mul_reg_waddr_i;
  assign src_waddr[2] = lsu_reg_waddr_i;
  assign src_data[0]  = alu_result_i;
  assign src_data[1]  = mul_result_i;
  assign src_data[2]  = lsu_result_i;
  assign src_id[0]    = alu_commit_id_i;
  assign src_id[1]    = mul_commit_id_i;
  assign src_id[2]    = lsu_commit_id_i;

`ifdef WBU_RR_ARB_EN
  logic [1:0] rr_ptr_q, rr_ptr_d, rr_base;
  logic [2:0] idx;
  logic       found;

  // Illegal pointer value 3 behaves as 0 and is written back as 0.
  always_comb begin
    // NOTE: every variable written here gets a default first so no latch is inferred.
    rr_base = (rr_ptr_q == 2'd3) ? 2'd0 : rr_ptr_q;
    gnt     = '0;
    idx     = '0;
    found   = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      idx = {1'b0, rr_base} + 3'(i);
      if (idx >= 3'd3) idx = idx - 3'd3;
      if (!found && req[idx[1:0]]) begin
        gnt[idx[1:0]] = 1'b1;
        found         = 1'b1;
      end
    end
    case (gnt)
      3'b001:  rr_ptr_d = 2'd1;
      3'b010:  rr_ptr_d = 2'd2;
      3'b100:  rr_ptr_d = 2'd0;
      default: rr_ptr_d = rr_base;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) rr_ptr_q <= 2'd0;
    else        rr_ptr_q <= rr_ptr_d;
  end
`else
  always_comb begin
    gnt = '0;
    if      (req[2]) gnt[2] = 1'b1;
    else if (req[1]) gnt[1] = 1'b1;
    else if (req[0]) gnt[0] = 1'b1;
  end
`endif

  // During reset every source is told it may move on; nothing is captured.
  assign alu_wb_ready_o = ~rst_n | ~alu_reg_we_i | gnt[0];
  assign mul_wb_ready_o = ~rst_n | ~mul_reg_we_i | gnt[1];
  assign lsu_wb_ready_o = ~rst_n | ~lsu_reg_we_i | gnt[2];

  logic                       reg_we_q, reg_we_d;
  logic                       commit_valid_q, commit_valid_d;
  logic [REG_ADDR_WIDTH-1:0]  reg_waddr_q, reg_waddr_d;
  logic [REG_DATA_WIDTH-1:0]  reg_wdata_q, reg_wdata_d;
  logic [COMMIT_ID_WIDTH-1:0] commit_id_q, commit_id_d;

  always_comb begin
    reg_we_d       = 1'b0;
    commit_valid_d = 1'b0;
    reg_waddr_d    = reg_waddr_q;
    reg_wdata_d    = reg_wdata_q;
    commit_id_d    = commit_id_q;
    for (int k = 0; k < NSRC; k++) begin
      if (gnt[k]) begin
        commit_valid_d = 1'b1;
        reg_we_d       = (src_waddr[k] != '0);
        reg_waddr_d    = src_waddr[k];
        reg_wdata_d    = src_data[k];
        commit_id_d    = src_id[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignments so all flops sample pre-edge values.
    if (!rst_n) begin
      reg_we_q       <= 1'b0;
      commit_valid_q <= 1'b0;
      reg_waddr_q    <= '0;
      reg_wdata_q    <= '0;
      commit_id_q    <= '0;
    end else begin
      reg_we_q       <= reg_we_d;
      commit_valid_q <= commit_valid_d;
      reg_waddr_q    <= reg_waddr_d;
      reg_wdata_q    <= reg_wdata_d;
      commit_id_q    <= commit_id_d;
    end
  end

  assign reg_we_o       = reg_we_q;
  assign commit_valid_o = commit_valid_q;
  assign reg_waddr_o    = reg_waddr_q;
  assign reg_wdata_o    = reg_wdata_q;
  assign commit_id_o    = commit_id_q;

endmodule

// File: tb/tb_wbu_result_arbiter.sv
// Self-checking bench for wbu_result_arbiter; a per-source result model predicts ready and the write-back port.
module tb_wbu_result_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int IW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]    we_i = '0;
  logic [AW-1:0] wa_i [3];
  logic [DW-1:0] wd_i [3];
  logic [IW-1:0] id_i [3];
  logic alu_rdy, mul_rdy, lsu_rdy;
  logic reg_we_o, commit_valid_o;
  logic [AW-1:0] reg_waddr_o;
  logic [DW-1:0] reg_wdata_o;
  logic [IW-1:0] commit_id_o;
  logic [2:0] rdy_vec;
  assign rdy_vec = {lsu_rdy, mul_rdy, alu_rdy};

  wbu_result_arbiter #(.NSRC(3), .REG_DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .COMMIT_ID_WIDTH(IW)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_reg_we_i(we_i[0]), .alu_reg_waddr_i(wa_i[0]), .alu_result_i(wd_i[0]),
    .alu_commit_id_i(id_i[0]), .alu_wb_ready_o(alu_rdy),
    .mul_reg_we_i(we_i[1]), .mul_reg_waddr_i(wa_i[1]), .mul_result_i(wd_i[1]),
    .mul_commit_id_i(id_i[1]), .mul_wb_ready_o(mul_rdy),
    .lsu_reg_we_i(we_i[2]), .lsu_reg_waddr_i(wa_i[2]), .lsu_result_i(wd_i[2]),
    .lsu_commit_id_i(id_i[2]), .lsu_wb_ready_o(lsu_rdy),
    .reg_we_o(reg_we_o), .reg_waddr_o(reg_waddr_o), .reg_wdata_o(reg_wdata_o),
    .commit_valid_o(commit_valid_o), .commit_id_o(commit_id_o)
  );

  // Reference model: pending result per source plus the expected write-back port.
  bit            s_v [3];
  logic [AW-1:0] s_a [3];
  logic [DW-1:0] s_d [3];
  logic [IW-1:0] s_id[3];
  int            m_ptr = 0;
  logic          exp_we = 0, exp_cv = 0;
  logic [AW-1:0] exp_a = '0;
  logic [DW-1:0] exp_d = '0;
  logic [IW-1:0] exp_id = '0;

  int n_vec = 0;
  int n_err = 0;

  function automatic int model_grant();
`ifdef WBU_RR_ARB_EN
    for (int i = 0; i < 3; i++)
      if (s_v[(m_ptr + i) % 3]) return (m_ptr + i) % 3;
`else
    for (int k = 2; k >= 0; k--)
      if (s_v[k]) return k;
`endif
    return -1;
  endfunction

  task automatic load(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [IW-1:0] id);
    s_v[k] = 1'b1; s_a[k] = a; s_d[k] = d; s_id[k] = id;
  endtask

  task automatic load_rand(input int k);
    load(k, AW'($urandom), $urandom, {2'($urandom), 2'(k)});
  endtask

  // Apply one clock cycle of stimulus and compare ready and the registered outputs to the model.
  task automatic cycle(input logic rst, output int g);
    logic exp_rdy;
    for (int k = 0; k < 3; k++) begin
      we_i[k] = s_v[k]; wa_i[k] = s_a[k]; wd_i[k] = s_d[k]; id_i[k] = s_id[k];
    end
    rst_n = rst;
    @(negedge clk);
    g = rst ? model_grant() : -1;
    for (int k = 0; k < 3; k++) begin
      exp_rdy = !rst || !s_v[k] || (g == k);
      n_vec++;
      if (rdy_vec[k] !== exp_rdy) begin
        n_err++;
        $display("FAIL ready[%0d] t=%0t got %b expected %b", k, $time, rdy_vec[k], exp_rdy);
      end
    end
    @(posedge clk);
    #1;
    if (!rst) begin
      exp_we = 0; exp_cv = 0; exp_a = '0; exp_d = '0; exp_id = '0; m_ptr = 0;
      for (int k = 0; k < 3; k++) s_v[k] = 1'b0;
    end else if (g >= 0) begin
      exp_cv = 1; exp_we = (s_a[g] != '0); exp_a = s_a[g]; exp_d = s_d[g]; exp_id = s_id[g];
      m_ptr = (g + 1) % 3;
      s_v[g] = 1'b0;
    end else begin
      exp_cv = 0; exp_we = 0;
    end
    n_vec += 5;
    if (reg_we_o !== exp_we)       begin n_err++; $display("FAIL reg_we t=%0t got %b expected %b", $time, reg_we_o, exp_we); end
    if (commit_valid_o !== exp_cv) begin n_err++; $display("FAIL commit_valid t=%0t got %b expected %b", $time, commit_valid_o, exp_cv); end
    if (reg_waddr_o !== exp_a)     begin n_err++; $display("FAIL reg_waddr t=%0t got %0d expected %0d", $time, reg_waddr_o, exp_a); end
    if (reg_wdata_o !== exp_d)     begin n_err++; $display("FAIL reg_wdata t=%0t got %h expected %h", $time, reg_wdata_o, exp_d); end
    if (commit_id_o !== exp_id)    begin n_err++; $display("FAIL commit_id t=%0t got %0d expected %0d", $time, commit_id_o, exp_id); end
  endtask

  task automatic do_reset();
    int g;
    for (int k = 0; k < 3; k++) s_v[k] = 1'b0;
    cycle(1'b0, g);
  endtask

  task automatic test_reset();
    int g;
    for (int c = 0; c < 2; c++) begin
      for (int k = 0; k < 3; k++) load_rand(k);
      cycle(1'b0, g);
    end
    cycle(1'b1, g);
  endtask

  task automatic test_single_alu();
    int g;
    load(0, 5'd5, 32'hDEADBEEF, 4'd3);
    cycle(1'b1, g);
    n_vec++;
    if (reg_wdata_o !== 32'hDEADBEEF || reg_waddr_o !== 5'd5 || commit_id_o !== 4'd3 || reg_we_o !== 1'b1) begin
      n_err++;
      $display("FAIL single_alu got we=%b a=%0d d=%h id=%0d expected we=1 a=5 d=deadbeef id=3",
               reg_we_o, reg_waddr_o, reg_wdata_o, commit_id_o);
    end
  endtask

  task automatic test_x0();
    int g;
    load(0, 5'd0, 32'h1234_5678, 4'd7);
    cycle(1'b1, g);
    n_vec++;
    if (commit_valid_o !== 1'b1 || reg_we_o !== 1'b0 || commit_id_o !== 4'd7) begin
      n_err++;
      $display("FAIL x0_write got cv=%b we=%b id=%0d expected cv=1 we=0 id=7", commit_valid_o, reg_we_o, commit_id_o);
    end
  endtask

  task automatic test_round_robin();
    int g;
    int want;
    do_reset();
    for (int k = 0; k < 3; k++) load_rand(k);
    for (int c = 0; c < 6; c++) begin
      cycle(1'b1, g);
`ifdef WBU_RR_ARB_EN
      want = c % 3;
`else
      want = 2;
`endif
      n_vec++;
      if (commit_id_o[1:0] !== 2'(want)) begin
        n_err++;
        $display("FAIL rr_order cycle %0d got src %0d expected src %0d", c, commit_id_o[1:0], want);
      end
      if (g >= 0) load_rand(g);
    end
    for (int k = 0; k < 3; k++) s_v[k] = 1'b0;
    cycle(1'b1, g);
  endtask

  task automatic test_fixed_priority();
    int g;
    do_reset();
    load_rand(0);
    load_rand(2);
    for (int c = 0; c < 3; c++) begin
      cycle(1'b1, g);
      if (g == 2) load_rand(2);
    end
    cycle(1'b1, g);
    cycle(1'b1, g);
`ifndef WBU_RR_ARB_EN
    n_vec++;
    if (commit_id_o[1:0] !== 2'd0 || commit_valid_o !== 1'b1) begin
      n_err++;
      $display("FAIL fixed_alu_after_lsu got src %0d cv=%b expected src 0 cv=1", commit_id_o[1:0], commit_valid_o);
    end
`endif
  endtask

  task automatic test_reset_midstream();
    int g;
    int want;
    do_reset();
    load_rand(0);
    cycle(1'b1, g);
    load_rand(1);
    cycle(1'b0, g);
    n_vec++;
    if (reg_we_o !== 1'b0 || commit_valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL midstream_reset got we=%b cv=%b expected we=0 cv=0", reg_we_o, commit_valid_o);
    end
    for (int k = 0; k < 3; k++) load_rand(k);
    cycle(1'b1, g);
`ifdef WBU_RR_ARB_EN
    want = 0;
`else
    want = 2;
`endif
    n_vec++;
    if (commit_id_o[1:0] !== 2'(want)) begin
      n_err++;
      $display("FAIL first_after_reset got src %0d expected src %0d", commit_id_o[1:0], want);
    end
    for (int k = 0; k < 3; k++) s_v[k] = 1'b0;
    cycle(1'b1, g);
  endtask

  task automatic test_random();
    int g;
    for (int c = 0; c < 300; c++) begin
      for (int k = 0; k < 3; k++)
        if (!s_v[k] && ($urandom_range(0, 1) == 1)) load_rand(k);
      cycle(1'b1, g);
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      s_v[k] = 1'b0; s_a[k] = '0; s_d[k] = '0; s_id[k] = '0;
      wa_i[k] = '0; wd_i[k] = '0; id_i[k] = '0;
    end
    test_reset();
    test_single_alu();
    test_x0();
    test_round_robin();
    test_fixed_priority();
    test_reset_midstream();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
